decoder_in_sync: RTL
====================

DECODER_IN_SYNC -- requirements
Module: decoder_in_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 7, code width matching the decoder io_in bus.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, legal range 1..15, consecutive stable cycles required to accept a code.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port io_in  input  WIDTH  raw asynchronous pad code.
REQ-006 SHALL have port code_o  output  WIDTH  head-of-queue code for the decoder stage.
REQ-007 SHALL have port code_valid  output  1  code_o holds a queued code.
REQ-008 SHALL have port code_ready  input  1  decoder consumes code_o this cycle.
REQ-009 SHALL have port overflow  output  1  sticky flag, code dropped due to full queue.
REQ-010 SHALL have port clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-011 SHALL pass io_in through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-012 SHALL keep candidate register cand and stable counter cnt (4 bits); sync2 != cand -> cand <= sync2, cnt <= 0.
REQ-013 SHALL increment cnt when sync2 == cand and cnt < DEBOUNCE_CYCLES; cnt saturates at DEBOUNCE_CYCLES.
REQ-014 SHALL generate a one-cycle accept when sync2 == cand and cnt == DEBOUNCE_CYCLES-1 (the cnt transition to DEBOUNCE_CYCLES).
REQ-015 SHALL on accept compare cand to last_code; differ -> push cand, last_code <= cand; equal -> no push.
REQ-016 SHALL buffer pushes in a 2-entry FIFO (registered, no combinational bypass); code_o = head entry, code_valid = FIFO not empty.
REQ-017 SHALL pop when code_valid && code_ready; code_o/code_valid SHALL NOT change while code_valid && !code_ready.
REQ-018 Latency: io_in change sampled at posedge N, held stable, empty FIFO -> code_valid high after posedge N+DEBOUNCE_CYCLES+3 (N+7 at default).
REQ-019 Glitch shorter than DEBOUNCE_CYCLES+1 cycles at sync2 SHALL produce no push.
REQ-020 Push with FIFO full and no pop SHALL drop the new code, set overflow, and still update last_code.
REQ-021 Simultaneous push and pop with FIFO full SHALL accept the push, no overflow.
REQ-022 Simultaneous push and pop with one entry SHALL leave one entry = new code.
REQ-023 Pop on empty FIFO SHALL be ignored; FIFO pointers wrap modulo 2.
REQ-024 clr_ovf SHALL clear overflow next edge; overflow set and clr_ovf in the same cycle -> overflow stays 1 (set wins).

Reset
REQ-025 rst_n low SHALL immediately clear sync1, sync2, cand, cnt, last_code, FIFO pointers/contents, overflow; code_o = 0, code_valid = 0.
REQ-026 Stable io_in = 0 after reset SHALL produce no push (matches last_code reset value).
REQ-027 Reset asserted mid-debounce or with queued codes SHALL discard all pending state; after release debounce restarts from cnt = 0.
REQ-028 rst_n release SHALL be synchronous to clk externally; the block SHALL NOT require extra reset synchronization.

Verification
REQ-029 Reset release, io_in = 7'b1001010 held, code_ready = 1 -> code_valid high 7 cycles after first sample, code_o = 7'b1001010, one cycle only.
REQ-030 io_in 0 -> 7'b0000001 for 3 cycles -> 0 -> code_valid never asserts, overflow = 0.
REQ-031 code_ready = 0, stable codes 7'h11, 7'h22, 7'h33 in sequence -> queue holds 7'h11, 7'h22; overflow = 1; then ready = 1 -> codes 7'h11 then 7'h22 in order, 7'h33 never.
REQ-032 Same code 7'h2A stable, removed briefly (< DEBOUNCE_CYCLES+1), restored -> exactly one push of 7'h2A.
REQ-033 FIFO full, push coincident with pop -> overflow stays 0, next outputs in order with new code last.
REQ-034 rst_n pulsed low with 2 entries queued and overflow = 1 -> code_valid = 0, overflow = 0 immediately, no stale code after release.

Source files
------------

// File: rtl/decoder_in_sync.sv
// Pad-code input stage: 2-flop synchronizer, debounce filter, change detector and a
// 2-entry registered queue feeding the decoder, with a sticky overflow flag.
module decoder_in_sync #(
    parameter int unsigned WIDTH           = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] code_o,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam logic [3:0] CntMax = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] CntAcc = 4'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2, cand, last_code, push_code;
    logic [3:0]       cnt;
    logic             accept, push_q;

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic             pop, full, wr_en;

    assign accept = (sync2 == cand) && (cnt == CntAcc);

    // Synchronizer, debounce counter and change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            cand      <= '0;
            cnt       <= '0;
            last_code <= '0;
            push_q    <= 1'b0;
            push_code <= '0;
        end else begin
            sync1  <= io_in;
            sync2  <= sync1;
            push_q <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt < CntMax) begin
                cnt <= cnt + 4'd1;
            end
            // Push is registered one stage so the queue write lands a cycle after accept.
            if (accept && (cand != last_code)) begin
                last_code <= cand;
                push_q    <= 1'b1;
                push_code <= cand;
            end
        end
    end

    assign code_valid = (count != 2'd0);
    assign full       = (count == 2'd2);
    assign pop        = code_valid && code_ready;
    // A pop frees the slot this cycle, so a full queue can still take the push.
    assign wr_en      = push_q && (!full || pop);
    assign code_o     = code_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push_q && !wr_en) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
